// File: rtl/iter_seq_ctrl.sv
// Sequencer for the iterative arithmetic datapath: start/load/iterate/done handshake
// and ownership of the iteration counter that addresses the shift/LUT stages.
module iter_seq_ctrl #(
  parameter int W     = 5,
  parameter int ITERS = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         BEG,
  input  logic         ACK,
  input  logic         ABORT,
  output logic         LD,
  output logic         ITER_EN,
  output logic [W-1:0] ITER_IDX,
  output logic         BUSY,
  output logic         READY
);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  // Terminal count; for ITERS = 2^W this truncates to all-ones.
  localparam logic [W-1:0] LAST = W'(ITERS - 1);

  state_t       state, state_nxt;
  logic [W-1:0] cnt, cnt_nxt;

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (BEG) state_nxt = LOAD;
      end
      LOAD: begin
        cnt_nxt   = '0;
        state_nxt = ABORT ? IDLE : ITER;
      end
      ITER: begin
        if (ABORT) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + W'(1);
        end
      end
      DONE: begin
        if (ACK) state_nxt = BEG ? LOAD : IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Flags are registered from the next state, so they always equal a decode of the
  // state register without any combinational path from the inputs.
  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      LD      <= 1'b0;
      ITER_EN <= 1'b0;
      BUSY    <= 1'b0;
      READY   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      LD      <= (state_nxt == LOAD);
      ITER_EN <= (state_nxt == ITER);
      BUSY    <= (state_nxt == LOAD) || (state_nxt == ITER);
      READY   <= (state_nxt == DONE);
    end
  end

  assign ITER_IDX = cnt;

endmodule

// File: doc/iter_seq_ctrl.md
Name: iter_seq_ctrl

Overview:
- Sequencer for the iterative arithmetic datapath; owns the 5-bit iteration counter.
- Accepts a start request, loads the datapath operand registers, then enables the datapath for exactly ITERS cycles while presenting the iteration index.
- Holds the result-valid flag until the consumer acknowledges it.
- Sits between the top-level control FSM and the iteration datapath (shift/add stages, angle LUT addressing).

Parameters:
- W, 5, width of iteration counter and ITER_IDX.
- ITERS, 16, number of datapath iterations per operation; legal range 1..2^W.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  reset, synchronous, active-high.
- BEG  input  1  start request; sampled only in IDLE, or in DONE together with ACK.
- ACK  input  1  consumer acknowledge of result; sampled only in DONE.
- ABORT  input  1  cancel the operation in progress; sampled only in LOAD and ITER.
- LD  output  1  one-cycle load strobe for the datapath operand registers.
- ITER_EN  output  1  datapath iteration enable.
- ITER_IDX  output  W  current iteration number, 0..ITERS-1; LUT/shift-amount address.
- BUSY  output  1  high in LOAD and ITER.
- READY  output  1  result valid; high in DONE.

Behaviour:
- States: IDLE, LOAD, ITER, DONE. Two-bit state register plus W-bit counter CNT; ITER_IDX = CNT.
- LD, ITER_EN, BUSY and READY are Moore decodes of the state register:
  - LD = (LOAD).
  - ITER_EN = (ITER).
  - BUSY = (LOAD or ITER).
  - READY = (DONE).
- RST=1 at an edge, in any state including mid-operation:
  - state goes to IDLE and CNT to 0.
  - All outputs read 0 from the next cycle.
  - RST has priority over BEG, ACK and ABORT.
- IDLE: BEG=1 -> LOAD; otherwise stay. CNT held at 0.
- LOAD:
  - Lasts exactly one cycle.
  - CNT <= 0.
  - ABORT=1 -> IDLE; otherwise -> ITER.
- ITER:
  - Each cycle with CNT != ITERS-1: CNT <= CNT+1.
  - CNT == ITERS-1: -> DONE, and CNT <= 0.
  - ABORT=1 overrides both: -> IDLE, CNT <= 0, READY is never asserted for that operation.
  - ITER_EN is therefore high for exactly ITERS consecutive cycles, with ITER_IDX = 0,1,...,ITERS-1.
- Counter arithmetic:
  - Counter is W bits; the terminal compare is against ITERS-1 truncated to W bits.
  - With ITERS = 2^W, the terminal count is all-ones and the counter wraps to 0 on exit. No other wrap occurs.
  - ITERS=1: ITER lasts a single cycle with ITER_IDX=0.
- DONE:
  - READY held high until ACK=1.
  - ACK=1, BEG=0 -> IDLE.
  - ACK=1, BEG=1 -> LOAD (back-to-back operation, no idle bubble).
  - ACK=0 -> stay; BEG is ignored.
- BEG asserted in LOAD or ITER is ignored, not queued. ACK outside DONE is ignored. ABORT in IDLE or DONE is ignored.
- Latency:
  - BEG sampled at edge k.
  - LD high during cycle k+1.
  - ITER_EN high during cycles k+2 .. k+1+ITERS.
  - READY high from cycle k+2+ITERS.
  - Total BEG-to-READY = ITERS+2 cycles.

Test Plan:
- Reset then single op (ITERS=16):
  - Stimulus: RST 2 cycles, BEG pulse at edge 0.
  - Required: LD=1 in cycle 1; ITER_EN=1 in cycles 2..17 with ITER_IDX 0..15; READY=1 from cycle 18.
  - ACK at cycle 20 -> IDLE, all outputs 0 in cycle 21.
- Held READY:
  - Stimulus: ACK kept 0 for 50 cycles after DONE, BEG=1 throughout.
  - Required: READY stays 1, BUSY stays 0, LD never pulses, ITER_IDX=0.
- Back-to-back:
  - Stimulus: in DONE, ACK=1 and BEG=1 in the same cycle.
  - Required: next cycle LD=1, READY=0; second READY arrives exactly 18 cycles after that ACK edge.
- Abort:
  - Stimulus: ABORT=1 when ITER_IDX=7.
  - Required: next cycle state IDLE, ITER_EN=0, ITER_IDX=0; READY stays 0; a new BEG restarts at ITER_IDX=0.
- Reset mid-operation:
  - Stimulus: RST=1 during ITER at ITER_IDX=10, with BEG=1 and ACK=1.
  - Required: next cycle all outputs 0, state IDLE; releasing RST with BEG=1 gives LD one cycle later.
- Boundary parameters:
  - ITERS=1: ITER_EN high for exactly 1 cycle with ITER_IDX=0, READY 3 cycles after BEG.
  - ITERS=32 (W=5): ITER_IDX runs 0..31, then READY=1 and ITER_IDX=0.
